// File: rtl/l2req_arbiter_rr_pkg.sv
// Shared L2 request field widths, unit encodings and arbiter state type.
// Flattened requester buses are sliced with these widths.
package l2req_arbiter_rr_pkg;

    localparam int L2_STRAND_W = 2;
    localparam int L2_UNIT_W   = 2;
    localparam int L2_OP_W     = 3;
    localparam int L2_WAY_W    = 2;
    localparam int L2_ADDR_W   = 26;
    localparam int L2_DATA_W   = 512;
    localparam int L2_MASK_W   = 64;
    localparam int PERF_CNT_W  = 32;

    localparam logic [L2_UNIT_W-1:0] UNIT_ICACHE = 2'd0;
    localparam logic [L2_UNIT_W-1:0] UNIT_DCACHE = 2'd1;
    localparam logic [L2_UNIT_W-1:0] UNIT_STBUF  = 2'd2;
    localparam logic [L2_UNIT_W-1:0] UNIT_EXT    = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } arb_state_e;

    // Increment modulo n; n need not be a power of two.
    function automatic int rr_wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/l2req_arbiter_rr_pick.sv
// Rotating first-set-bit finder: searches i_ptr, i_ptr+1, ... wrapping at N.
// Pure combinational, shared with other round-robin arbiters.
module l2req_arbiter_rr_pick
    import l2req_arbiter_rr_pkg::*;
#(
    parameter int N = 3,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] i_cand,
    input  logic [W-1:0] i_ptr,
    output logic         o_found,
    output logic [W-1:0] o_idx
);

    int w_pos;

    // Walk the offsets backwards so the smallest offset from i_ptr wins.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_pos   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            w_pos = (int'(i_ptr) + k) % N;
            if (i_cand[w_pos]) begin
                o_found = 1'b1;
                o_idx   = W'(w_pos);
            end
        end
    end

endmodule

// File: rtl/l2req_arbiter_rr.sv
// N-way round-robin L2 request arbiter/mux with hold-until-ack grants.
// Optional counters: define L2REQ_ARB_PERF_EN to build the perf counters.
//
// state   | meaning
// ST_IDLE | no grant; pick from all valid requesters
// ST_HOLD | grant_idx owns the bus until ack or withdrawal
module l2req_arbiter_rr
    import l2req_arbiter_rr_pkg::*;
#(
    parameter int NUM_REQUESTERS  = 3,
    parameter int GRANT_IDX_WIDTH = $clog2(NUM_REQUESTERS)
) (
    input  logic                                 i_clk,
    input  logic                                 i_reset,
    input  logic [NUM_REQUESTERS-1:0]            i_req_valid,
    input  logic [NUM_REQUESTERS*L2_STRAND_W-1:0] i_req_strand,
    input  logic [NUM_REQUESTERS*L2_UNIT_W-1:0]  i_req_unit,
    input  logic [NUM_REQUESTERS*L2_OP_W-1:0]    i_req_op,
    input  logic [NUM_REQUESTERS*L2_WAY_W-1:0]   i_req_way,
    input  logic [NUM_REQUESTERS*L2_ADDR_W-1:0]  i_req_address,
    input  logic [NUM_REQUESTERS*L2_DATA_W-1:0]  i_req_data,
    input  logic [NUM_REQUESTERS*L2_MASK_W-1:0]  i_req_mask,
    output logic [NUM_REQUESTERS-1:0]            o_req_selected,
    output logic                                 o_l2req_valid,
    input  logic                                 i_l2req_ack,
    output logic [L2_STRAND_W-1:0]               o_l2req_strand,
    output logic [L2_UNIT_W-1:0]                 o_l2req_unit,
    output logic [L2_OP_W-1:0]                   o_l2req_op,
    output logic [L2_WAY_W-1:0]                  o_l2req_way,
    output logic [L2_ADDR_W-1:0]                 o_l2req_address,
    output logic [L2_DATA_W-1:0]                 o_l2req_data,
    output logic [L2_MASK_W-1:0]                 o_l2req_mask,
    output logic [NUM_REQUESTERS*PERF_CNT_W-1:0] o_perf_grant_count,
    output logic [PERF_CNT_W-1:0]                o_perf_stall_cycles
);

    localparam int N = NUM_REQUESTERS;
    localparam int W = GRANT_IDX_WIDTH;

    arb_state_e r_state, w_state_nxt;
    logic [W-1:0] r_grant_idx, w_grant_idx_nxt;
    logic [W-1:0] r_rr_ptr, w_rr_ptr_nxt;
    logic [W-1:0] w_ptr_inc, w_pick_ptr, w_pick_idx;
    logic [N-1:0] w_cand;
    logic         w_pick_found, w_grant_active, w_gnt_req_valid, w_ack;
    int           w_gidx;

    assign w_gidx          = int'(r_grant_idx);
    assign w_grant_active  = (r_state == ST_HOLD);
    assign w_gnt_req_valid = i_req_valid[r_grant_idx];
    assign w_ack           = w_grant_active & w_gnt_req_valid & i_l2req_ack;
    assign w_ptr_inc       = W'(rr_wrap_inc(w_gidx, N));

    // The acked requester is masked so it cannot win again in its ack cycle;
    // searching from the post-ack pointer keeps the rotation fair.
    always_comb begin
        w_cand = i_req_valid;
        if (w_ack) begin
            w_cand[r_grant_idx] = 1'b0;
        end
    end

    assign w_pick_ptr = w_ack ? w_ptr_inc : r_rr_ptr;

    l2req_arbiter_rr_pick #(
        .N (N),
        .W (W)
    ) u_pick (
        .i_cand  (w_cand),
        .i_ptr   (w_pick_ptr),
        .o_found (w_pick_found),
        .o_idx   (w_pick_idx)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_grant_idx <= '0;
            r_rr_ptr    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant_idx <= w_grant_idx_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_grant_idx_nxt = r_grant_idx;
        w_rr_ptr_nxt    = r_rr_ptr;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_found) begin
                    w_state_nxt     = ST_HOLD;
                    w_grant_idx_nxt = w_pick_idx;
                end
            end
            ST_HOLD: begin
                if (w_ack) begin
                    w_rr_ptr_nxt = w_ptr_inc;
                    if (w_pick_found) begin
                        w_grant_idx_nxt = w_pick_idx;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else if (!w_gnt_req_valid) begin
                    // Withdrawal: drop the grant, leave the pointer alone.
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_req_selected = '0;
        for (int i = 0; i < N; i++) begin
            o_req_selected[i] = w_grant_active && (w_gidx == i);
        end
    end

    assign o_l2req_valid   = w_grant_active & w_gnt_req_valid;
    assign o_l2req_strand  = i_req_strand[w_gidx*L2_STRAND_W +: L2_STRAND_W];
    assign o_l2req_unit    = i_req_unit[w_gidx*L2_UNIT_W +: L2_UNIT_W];
    assign o_l2req_op      = i_req_op[w_gidx*L2_OP_W +: L2_OP_W];
    assign o_l2req_way     = i_req_way[w_gidx*L2_WAY_W +: L2_WAY_W];
    assign o_l2req_address = i_req_address[w_gidx*L2_ADDR_W +: L2_ADDR_W];
    assign o_l2req_data    = i_req_data[w_gidx*L2_DATA_W +: L2_DATA_W];
    assign o_l2req_mask    = i_req_mask[w_gidx*L2_MASK_W +: L2_MASK_W];

`ifdef L2REQ_ARB_PERF_EN
    logic [PERF_CNT_W-1:0] r_perf_grant [N];
    logic [PERF_CNT_W-1:0] r_perf_stall;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < N; i++) begin
                r_perf_grant[i] <= '0;
            end
            r_perf_stall <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (i_l2req_ack && o_req_selected[i]) begin
                    r_perf_grant[i] <= r_perf_grant[i] + 1'b1;
                end
            end
            if (o_l2req_valid && !i_l2req_ack) begin
                r_perf_stall <= r_perf_stall + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_perf
        assign o_perf_grant_count[g*PERF_CNT_W +: PERF_CNT_W] = r_perf_grant[g];
    end
    assign o_perf_stall_cycles = r_perf_stall;
`else
    assign o_perf_grant_count  = '0;
    assign o_perf_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_l2req_arbiter_rr.sv
// Directed bench for l2req_arbiter_rr: a 3-way and a 5-way instance.
module tb_l2req_arbiter_rr;
    import l2req_arbiter_rr_pkg::*;

    localparam int N3 = 3;
    localparam int N5 = 5;
`ifdef L2REQ_ARB_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    logic [N3-1:0]    a_valid, a_sel;
    logic [2*N3-1:0]  a_strand, a_unit, a_way;
    logic [3*N3-1:0]  a_op;
    logic [26*N3-1:0] a_addr;
    logic [512*N3-1:0] a_data;
    logic [64*N3-1:0] a_mask;
    logic             a_l2v, a_ack;
    logic [1:0]       a_ostrand, a_ounit, a_oway;
    logic [2:0]       a_oop;
    logic [25:0]      a_oaddr;
    logic [511:0]     a_odata;
    logic [63:0]      a_omask;
    logic [32*N3-1:0] a_pgc;
    logic [31:0]      a_pstall;

    logic [N5-1:0]    b_valid, b_sel;
    logic [2*N5-1:0]  b_strand, b_unit, b_way;
    logic [3*N5-1:0]  b_op;
    logic [26*N5-1:0] b_addr;
    logic [512*N5-1:0] b_data;
    logic [64*N5-1:0] b_mask;
    logic             b_l2v, b_ack;
    logic [1:0]       b_ostrand, b_ounit, b_oway;
    logic [2:0]       b_oop;
    logic [25:0]      b_oaddr;
    logic [511:0]     b_odata;
    logic [63:0]      b_omask;
    logic [32*N5-1:0] b_pgc;
    logic [31:0]      b_pstall;

    l2req_arbiter_rr #(.NUM_REQUESTERS(N3)) dut3 (
        .i_clk(clk), .i_reset(reset), .i_req_valid(a_valid),
        .i_req_strand(a_strand), .i_req_unit(a_unit), .i_req_op(a_op),
        .i_req_way(a_way), .i_req_address(a_addr), .i_req_data(a_data),
        .i_req_mask(a_mask), .o_req_selected(a_sel), .o_l2req_valid(a_l2v),
        .i_l2req_ack(a_ack), .o_l2req_strand(a_ostrand), .o_l2req_unit(a_ounit),
        .o_l2req_op(a_oop), .o_l2req_way(a_oway), .o_l2req_address(a_oaddr),
        .o_l2req_data(a_odata), .o_l2req_mask(a_omask),
        .o_perf_grant_count(a_pgc), .o_perf_stall_cycles(a_pstall)
    );

    l2req_arbiter_rr #(.NUM_REQUESTERS(N5)) dut5 (
        .i_clk(clk), .i_reset(reset), .i_req_valid(b_valid),
        .i_req_strand(b_strand), .i_req_unit(b_unit), .i_req_op(b_op),
        .i_req_way(b_way), .i_req_address(b_addr), .i_req_data(b_data),
        .i_req_mask(b_mask), .o_req_selected(b_sel), .o_l2req_valid(b_l2v),
        .i_l2req_ack(b_ack), .o_l2req_strand(b_ostrand), .o_l2req_unit(b_ounit),
        .o_l2req_op(b_oop), .o_l2req_way(b_oway), .o_l2req_address(b_oaddr),
        .o_l2req_data(b_odata), .o_l2req_mask(b_omask),
        .o_perf_grant_count(b_pgc), .o_perf_stall_cycles(b_pstall)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    logic [31:0] b_pgc_sum;

    initial begin
        reset = 1'b1;
        a_valid = '0; a_ack = 1'b0; b_valid = '0; b_ack = 1'b0;
        a_strand = '0; a_unit = '0; a_op = '0; a_way = '0;
        a_addr = '0; a_data = '0; a_mask = '0;
        b_strand = '0; b_unit = '0; b_op = '0; b_way = '0;
        b_addr = '0; b_data = '0; b_mask = '0;
        for (int i = 0; i < N3; i++) begin
            a_strand[2*i +: 2] = 2'(i);
            a_unit[2*i +: 2]   = 2'(i);
            a_op[3*i +: 3]     = 3'(i + 4);
            a_way[2*i +: 2]    = 2'(3 - i);
            a_addr[26*i +: 26] = 26'h0abc000 + 26'(i);
            a_data[512*i +: 512] = {8{64'hdead_0000_0000_0000 + 64'(i)}};
            a_mask[64*i +: 64] = 64'hff00 + 64'(i);
        end
        a_addr[26 +: 26] = 26'h1234;
        for (int i = 0; i < N5; i++) begin
            b_strand[2*i +: 2] = 2'(i + 1);
            b_unit[2*i +: 2]   = 2'(i);
            b_op[3*i +: 3]     = 3'(i);
            b_way[2*i +: 2]    = 2'(i + 2);
            b_addr[26*i +: 26] = 26'h2000000 + 26'(i);
            b_data[512*i +: 512] = {8{64'hbeef_0000_0000_0000 + 64'(i)}};
            b_mask[64*i +: 64] = 64'h5500 + 64'(i);
        end
        step(); step();
        reset = 1'b0;
        step();

        // Reset state and idle with nothing valid
        check_eq("rst_l2v", 64'(a_l2v), 64'd0);
        check_eq("rst_sel", 64'(a_sel), 64'd0);
        check_eq("rst_sel5", 64'(b_sel), 64'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            check_eq("idle_l2v", 64'(a_l2v), 64'd0);
            check_eq("idle_sel", 64'(a_sel), 64'd0);
        end
        a_ack = 1'b1;
        step();
        check_eq("stray_ack_sel", 64'(a_sel), 64'd0);
        a_ack = 1'b0;

        // Single requester 1: one-cycle latency, field mux, hold, drop after ack
        a_valid = 3'b010;
        #1 check_eq("lat_l2v", 64'(a_l2v), 64'd0);
        step();
        check_eq("r1_l2v", 64'(a_l2v), 64'd1);
        check_eq("r1_sel", 64'(a_sel), 64'b010);
        check_eq("r1_addr", 64'(a_oaddr), 64'h1234);
        check_eq("r1_strand", 64'(a_ostrand), 64'd1);
        check_eq("r1_unit", 64'(a_ounit), 64'd1);
        check_eq("r1_op", 64'(a_oop), 64'd5);
        check_eq("r1_way", 64'(a_oway), 64'd2);
        check_eq("r1_mask", a_omask, 64'hff01);
        check_eq("r1_data", 64'(a_odata == {8{64'hdead_0000_0000_0001}}), 64'd1);
        step();
        check_eq("r1_hold_sel", 64'(a_sel), 64'b010);
        check_eq("r1_hold_l2v", 64'(a_l2v), 64'd1);
        a_ack = 1'b1;
        step();
        a_ack = 1'b0; a_valid = 3'b000;
        #1 check_eq("r1_after_ack_sel", 64'(a_sel), 64'd0);
        check_eq("r1_after_ack_l2v", 64'(a_l2v), 64'd0);

        // Reset while holding a grant
        a_valid = 3'b001;
        step();
        check_eq("hold_pre_rst_l2v", 64'(a_l2v), 64'd1);
        reset = 1'b1;
        step();
        check_eq("rst_in_hold_l2v", 64'(a_l2v), 64'd0);
        check_eq("rst_in_hold_sel", 64'(a_sel), 64'd0);
        reset = 1'b0; a_valid = 3'b000;
        step();

        // All valid, ack every cycle: 0,1,2,0,1,2 with no bubble
        a_valid = 3'b111;
        step();
        a_ack = 1'b1;
        for (int k = 0; k < 6; k++) begin
            check_eq("rr_sel", 64'(a_sel), 64'(3'b001 << (k % 3)));
            check_eq("rr_l2v", 64'(a_l2v), 64'd1);
            step();
        end
        a_ack = 1'b0; a_valid = 3'b000;
        step();

        // Withdrawal by grantee 2 while req 0 waits; pointer must stay at 1
        a_valid = 3'b001;
        step();
        check_eq("wd_g0_sel", 64'(a_sel), 64'b001);
        a_ack = 1'b1;
        step();
        a_ack = 1'b0; a_valid = 3'b100;
        #1 check_eq("wd_idle_sel", 64'(a_sel), 64'd0);
        step();
        check_eq("wd_g2_sel", 64'(a_sel), 64'b100);
        a_valid = 3'b101;
        step();
        check_eq("wd_hold2_sel", 64'(a_sel), 64'b100);
        a_valid = 3'b001;
        step();
        check_eq("wd_drop_sel", 64'(a_sel), 64'd0);
        check_eq("wd_drop_l2v", 64'(a_l2v), 64'd0);
        step();
        check_eq("wd_regrant0_sel", 64'(a_sel), 64'b001);
        check_eq("wd_regrant0_l2v", 64'(a_l2v), 64'd1);
        a_valid = 3'b000;
        step();
        check_eq("wd2_drop_sel", 64'(a_sel), 64'd0);
        a_valid = 3'b101;
        step();
        check_eq("wd_ptr_keep_sel", 64'(a_sel), 64'b100);
        a_valid = 3'b000;
        step();

        // Counters: 4 requests to req 0, each held 3 cycles including the ack cycle
        reset = 1'b1;
        step();
        reset = 1'b0;
        a_valid = 3'b001;
        step();
        check_eq("perf_g0_sel", 64'(a_sel), 64'b001);
        for (int r = 0; r < 4; r++) begin
            a_ack = 1'b0;
            step(); step();
            a_ack = 1'b1;
            step();
            a_ack = 1'b0;
            if (r < 3) step();
        end
        a_valid = 3'b000;
        step();
        check_eq("perf_grant0", 64'(a_pgc[31:0]), PERF ? 64'd4 : 64'd0);
        check_eq("perf_grant1", 64'(a_pgc[63:32]), 64'd0);
        check_eq("perf_grant2", 64'(a_pgc[95:64]), 64'd0);
        check_eq("perf_stall", 64'(a_pstall), PERF ? 64'd8 : 64'd0);

        // N=5: drive rr_ptr to 4, then 5'b00011 grants 0 then 1
        b_valid = 5'b01000;
        step();
        check_eq("n5_g3_sel", 64'(b_sel), 64'b01000);
        b_ack = 1'b1;
        step();
        b_ack = 1'b0; b_valid = 5'b00011;
        #1 check_eq("n5_idle_sel", 64'(b_sel), 64'd0);
        step();
        check_eq("n5_wrap_g0_sel", 64'(b_sel), 64'b00001);
        b_ack = 1'b1;
        step();
        check_eq("n5_b2b_g1_sel", 64'(b_sel), 64'b00010);
        check_eq("n5_b2b_g1_l2v", 64'(b_l2v), 64'd1);
        b_valid = 5'b00010;
        step();
        check_eq("n5_idle2_sel", 64'(b_sel), 64'd0);
        b_ack = 1'b0; b_valid = 5'b10000;
        step();
        check_eq("n5_g4_sel", 64'(b_sel), 64'b10000);
        check_eq("n5_g4_addr", 64'(b_oaddr), 64'h2000004);
        check_eq("n5_g4_strand", 64'(b_ostrand), 64'd1);
        check_eq("n5_g4_unit", 64'(b_ounit), 64'd0);
        check_eq("n5_g4_op", 64'(b_oop), 64'd4);
        check_eq("n5_g4_way", 64'(b_oway), 64'd2);
        check_eq("n5_g4_mask", b_omask, 64'h5504);
        check_eq("n5_g4_data", 64'(b_odata == {8{64'hbeef_0000_0000_0004}}), 64'd1);
        b_valid = 5'b10011; b_ack = 1'b1;
        step();
        check_eq("n5_ptr_wrap_sel", 64'(b_sel), 64'b00001);
        check_eq("n5_ptr_wrap_l2v", 64'(b_l2v), 64'd1);
        b_ack = 1'b0; b_valid = 5'b00000;
        step();
        b_pgc_sum = '0;
        for (int i = 0; i < N5; i++) b_pgc_sum = b_pgc_sum + b_pgc[32*i +: 32];
        check_eq("n5_perf_sum", 64'(b_pgc_sum), PERF ? 64'd4 : 64'd0);
        check_eq("n5_perf_g1", 64'(b_pgc[63:32]), PERF ? 64'd1 : 64'd0);
        check_eq("n5_perf_stall", 64'(b_pstall), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/l2req_arbiter_rr.md
Name: l2req_arbiter_rr

Overview:
- Parametrised N-way successor to the fixed three-source L2 request arbiter/mux (icache, dcache, store buffer).
- Arbitrates among NUM_REQUESTERS L1-side L2 request ports (icache, dcache, stbuf, plus extra units such as a texture/DMA port) onto the single core L2 request bus.
- Uses registered round-robin grant with hold-until-ack semantics and back-to-back grants with no bubble.
- Sits in core between the L1 caches/store buffer and the L2 interface.

Parameters:
- NUM_REQUESTERS, 3, number of requester ports; legal 2..8, not necessarily a power of two.
- GRANT_IDX_WIDTH, $clog2(NUM_REQUESTERS), width of the grant index and rotation pointer; derived, do not override.

Ports:
- clk  in  1  clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  N  per-requester request valid.
- req_strand  in  2N  flattened strand fields; requester i occupies bits [2i+1:2i]. Other req_* fields are packed the same way.
- req_unit  in  2N  flattened unit fields.
- req_op  in  3N  flattened op fields.
- req_way  in  2N  flattened way fields.
- req_address  in  26N  flattened line addresses.
- req_data  in  512N  flattened line data.
- req_mask  in  64N  flattened byte masks.
- req_selected  out  N  one-hot; requester i owns the bus. Requester ack = l2req_ack & req_selected[i].
- l2req_valid  out  1  L2 request valid.
- l2req_ack  in  1  L2 accepted the current request.
- l2req_strand/unit/op/way/address/data/mask  out  2/2/3/2/26/512/64  muxed fields of the granted requester.
- perf_grant_count  out  32N  per-requester accepted-request counters (see Optional Feature).
- perf_stall_cycles  out  32  cycles with l2req_valid & ~l2req_ack.

Behaviour:
- State: grant_active (1b), grant_idx (GRANT_IDX_WIDTH), rr_ptr (GRANT_IDX_WIDTH); all registered.
- Reset: grant_active=0, grant_idx=0, rr_ptr=0. Next cycle: l2req_valid=0, req_selected=0. Reset mid-transaction abandons the grant; no ack is forwarded.
- Outputs:
  - l2req_valid = grant_active & req_valid[grant_idx].
  - req_selected = grant_active ? onehot(grant_idx) : 0.
  - l2req_* fields are a combinational mux of requester grant_idx; don't-care when l2req_valid=0.
  - Requesters hold their fields stable while valid until acked; this matches existing L1/stbuf behaviour.
- Candidate set C:
  - IDLE: C = req_valid.
  - Ack cycle: C = req_valid with bit grant_idx cleared, so the acked requester cannot be re-granted in the same cycle.
- Pick: first set bit of C searching rr_ptr, rr_ptr+1, ..., wrapping from N-1 to 0 (modulo N, not modulo 2^width).
- IDLE (grant_active=0):
  - If C != 0: grant_active<=1, grant_idx<=pick. l2req_valid rises one cycle after req_valid (1-cycle arbitration latency).
- HOLD (grant_active=1):
  - No ack and req_valid[grant_idx]=1: hold grant; all fields stable.
  - l2req_ack=1: rr_ptr<=(grant_idx+1) mod N. If C != 0, grant_idx<=pick and stay HOLD (zero-bubble back-to-back). Otherwise grant_active<=0.
  - req_valid[grant_idx]=0 without ack (withdrawal): grant_active<=0, rr_ptr unchanged; re-arbitrate next cycle.
- l2req_ack while l2req_valid=0 is ignored.
- Fairness: with all N requesters continuously valid, each is granted exactly once per N accepted requests.

Optional Feature:
- Macro L2REQ_ARB_PERF_EN.
- Defined:
  - perf_grant_count[i] increments on each cycle with l2req_ack & req_selected[i].
  - perf_stall_cycles increments on l2req_valid & ~l2req_ack.
  - All counters are 32-bit, wrap at 2^32-1 -> 0, and clear on reset.
- Undefined: ports remain and are tied to 0; no counter flops are synthesised.

Decomposition:
- Shared header l2_cache.h: L2 field widths (strand 2, unit 2, op 3, way 2, address 26, data 512, mask 64) and UNIT_* constants. Flattened bus slicing uses these widths.
- Sub-module rr_pick (combinational): inputs candidate vector and pointer; outputs found flag and index. Reused by future multi-core L2 input arbitration.

Test Plan:
- Reset, then req_valid=3'b000 -> l2req_valid=0, req_selected=0 indefinitely. Assert reset while in HOLD -> l2req_valid=0 the next cycle.
- N=3, only req 1 valid at cycle 0 with address 26'h1234 -> cycle 1: l2req_valid=1, req_selected=3'b010, l2req_address=26'h1234. Held until ack; drops the cycle after ack if req 1 deasserts.
- N=3, all valid continuously, ack every cycle once granted -> grant sequence 0,1,2,0,1,2 with no idle cycle between grants.
- N=5 (non-power-of-two), rr_ptr=4, valid=5'b00011 -> grant 0, then 1; pointer never selects index 5-7.
- Grantee 2 drops valid without ack while req 0 valid -> grant_active clears, req 0 granted the following cycle, rr_ptr unchanged.
- With L2REQ_ARB_PERF_EN: 4 requests to req 0, each held 3 cycles before ack -> perf_grant_count[0]=4, perf_stall_cycles=8. Without the macro -> both counters read 0.
